// File: rtl/inout_gen_stream.sv
// Parametrised NTT test-vector generator: streams N/LANES packed words over valid/ready
// and serves a registered random-access read port. Optional LFSR mode via INOUT_GEN_LFSR_EN.
module inout_gen_stream #(
   parameter int COEF_W = 8,
   parameter int LANES  = 2,
   parameter int N      = 256,
   parameter int ADDR_W = $clog2(N / LANES)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [1:0]              mode,
   input  logic [COEF_W-1:0]       seed,
   input  logic [COEF_W-1:0]       step,
   output logic                    busy,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*COEF_W-1:0] out_data,
   output logic                    out_last,
   output logic                    done,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic [LANES*COEF_W-1:0] rd_data
);
   // state  | meaning
   // S_IDLE | waiting for start; cfg holds the last accepted configuration
   // S_RUN  | streaming word k; out_valid and busy high

   localparam int WORD_W = LANES * COEF_W;
   localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N / LANES - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;
   state_t state_q, state_d;

   logic [1:0]        mode_q;
   logic [COEF_W-1:0] seed_q;
   logic [COEF_W-1:0] step_q;
   logic [ADDR_W-1:0] k_q;
   logic              done_q;
   logic              launch;
   logic              xfer;
   logic              last_xfer;
   logic [WORD_W-1:0] stream_word;
   logic [WORD_W-1:0] rd_word;

   function automatic logic [COEF_W-1:0] coef(input logic [1:0] m,
                                              input logic [COEF_W-1:0] s,
                                              input logic [COEF_W-1:0] st,
                                              input logic [COEF_W-1:0] i);
      case (m)
         2'd1:    coef = s;
         2'd2:    coef = s + i * st;
         default: coef = s + i;
      endcase
   endfunction

   // Index only matters modulo 2^COEF_W, so truncating it before the multiply is exact.
   function automatic logic [WORD_W-1:0] word_at(input logic [1:0] m,
                                                 input logic [COEF_W-1:0] s,
                                                 input logic [COEF_W-1:0] st,
                                                 input logic [ADDR_W-1:0] kk);
      logic [WORD_W-1:0] w;
      w = '0;
      for (int j = 0; j < LANES; j++)
         w[(LANES-j)*COEF_W-1 -: COEF_W] = coef(m, s, st, COEF_W'(int'(kk) * LANES + j));
      return w;
   endfunction

   assign busy      = (state_q == S_RUN);
   assign out_valid = (state_q == S_RUN);
   assign out_last  = (state_q == S_RUN) && (k_q == K_LAST);
   assign done      = done_q;
   assign launch    = (state_q == S_IDLE) && start;
   assign xfer      = out_valid && out_ready;
   assign last_xfer = xfer && out_last;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_xfer) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mode_q  <= '0;
         seed_q  <= '0;
         step_q  <= '0;
         k_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= last_xfer;
         if (launch) begin
            mode_q <= mode;
            seed_q <= seed;
            step_q <= step;
            k_q    <= '0;
         end else if (xfer) begin
            k_q <= last_xfer ? '0 : k_q + ADDR_W'(1);
         end
      end
   end

`ifdef INOUT_GEN_LFSR_EN
   // Galois form of x^32+x^22+x^2+x+1; the seed OR keeps the state nonzero. Needs COEF_W <= 16.
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   localparam logic [31:0] LFSR_INIT = 32'hACE1_0000;

   logic [31:0]       lfsr_q;
   logic [31:0]       lfsr_adv;
   logic [WORD_W-1:0] lfsr_word;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction

   always_comb begin
      logic [31:0] s;
      s         = lfsr_q;
      lfsr_word = '0;
      for (int j = 0; j < LANES; j++) begin
         s = lfsr_next(s);
         lfsr_word[(LANES-j)*COEF_W-1 -: COEF_W] = s[COEF_W-1:0];
      end
      lfsr_adv = s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lfsr_q <= LFSR_INIT;
      else if (launch)
         lfsr_q <= LFSR_INIT | 32'(seed);
      else if (xfer)
         lfsr_q <= lfsr_adv;
   end

   always_comb begin
      stream_word = word_at(mode_q, seed_q, step_q, k_q);
      rd_word     = word_at(mode_q, seed_q, step_q, rd_addr);
      if (mode_q == 2'd3) begin
         stream_word = lfsr_word;
         rd_word     = '0;
      end
   end
`else
   always_comb begin
      stream_word = word_at(mode_q, seed_q, step_q, k_q);
      rd_word     = word_at(mode_q, seed_q, step_q, rd_addr);
   end
`endif

   assign out_data = out_valid ? stream_word : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_data <= '0;
      else
         rd_data <= rd_word;
   end

endmodule

// File: tb/tb_inout_gen_stream.sv
// Self-checking bench for inout_gen_stream; compile with INOUT_GEN_LFSR_EN to cover the LFSR mode.
module tb_inout_gen_stream;
   localparam int COEF_W = 8;
   localparam int LANES  = 2;
   localparam int N      = 256;
   localparam int ADDR_W = 7;
   localparam int WORDS  = N / LANES;
   localparam int MASK   = (1 << COEF_W) - 1;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    start = 1'b0;
   logic [1:0]              mode = '0;
   logic [COEF_W-1:0]       seed = '0;
   logic [COEF_W-1:0]       step = '0;
   logic                    busy;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [LANES*COEF_W-1:0] out_data;
   logic                    out_last;
   logic                    done;
   logic [ADDR_W-1:0]       rd_addr = '0;
   logic [LANES*COEF_W-1:0] rd_data;

   int total = 0;
   int bad   = 0;
   logic [31:0] lfsr_exp [WORDS];

   inout_gen_stream #(.COEF_W(COEF_W), .LANES(LANES), .N(N), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed), .step(step),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .done(done), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

`ifdef INOUT_GEN_LFSR_EN
   localparam bit LFSR_ON = 1'b1;
`else
   localparam bit LFSR_ON = 1'b0;
`endif

   function automatic int coef_model(input int m, input int s, input int st, input int i);
      case (m)
         1:       return s;
         2:       return (s + i * st) % (1 << COEF_W);
         default: return (s + i) % (1 << COEF_W);
      endcase
   endfunction

   // Expected stream word; LFSR words come from the precomputed coefficient sequence.
   function automatic logic [31:0] exp_word(input int m, input int s, input int st, input int k);
      logic [31:0] w;
      if (m == 3 && LFSR_ON) return lfsr_exp[k];
      w = 0;
      for (int j = 0; j < LANES; j++)
         w = (w << COEF_W) | 32'(coef_model(m, s, st, k * LANES + j));
      return w;
   endfunction

   function automatic logic [31:0] exp_rd(input int m, input int s, input int st, input int a);
      if (m == 3 && LFSR_ON) return 0;
      return exp_word(m, s, st, a);
   endfunction

   task automatic lfsr_model(input int s);
      logic [31:0] st;
      st = 32'hACE1_0000 | 32'(s & MASK);
      for (int k = 0; k < WORDS; k++) begin
         lfsr_exp[k] = 0;
         for (int j = 0; j < LANES; j++) begin
            st = st[0] ? ((st >> 1) ^ 32'h8020_0003) : (st >> 1);
            lfsr_exp[k] = (lfsr_exp[k] << COEF_W) | (st & MASK);
         end
      end
   endtask

   // Launches at the current point (#1 after an edge) and follows the stream to its done cycle.
   task automatic run_stream(input int m, input int s, input int st, input bit rnd,
                             input int poke_k, input int abort_k);
      int k;
      int cycles;
      bit rdy;
      lfsr_model(s);
      mode = m[1:0]; seed = s[COEF_W-1:0]; step = st[COEF_W-1:0]; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("launch_busy", busy, 1);
      check("launch_valid", out_valid, 1);
      check("launch_done", done, 0);
      k = 0;
      cycles = 0;
      while (k < WORDS) begin
         if (k == abort_k) begin
            rst_n = 1'b0;
            #1;
            check("abort_valid", out_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_data", out_data, 0);
            check("abort_last", out_last, 0);
            check("abort_done", done, 0);
            out_ready = 1'b0;
            return;
         end
         check($sformatf("data m%0d k%0d", m, k), out_data, exp_word(m, s, st, k));
         check($sformatf("last k%0d", k), out_last, (k == WORDS - 1));
         check("valid_run", out_valid, 1);
         check("done_run", done, 0);
         if (k == poke_k) begin
            start = 1'b1; mode = 2'd1; seed = 8'h77; step = 8'h11;
         end
         rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         out_ready = rdy;
         @(posedge clk); #1;
         start = 1'b0;
         if (rdy) k++;
         cycles++;
         if (cycles > 4 * WORDS + 50) begin
            total++; bad++;
            $error("FAIL timeout stream cycles=%0d words=%0d", cycles, k);
            break;
         end
      end
      check("end_done", done, 1);
      check("end_busy", busy, 0);
      check("end_valid", out_valid, 0);
      out_ready = 1'b0;
   endtask

   task automatic rd_probe(input int m, input int s, input int st, input int a);
      rd_addr = a[ADDR_W-1:0];
      @(posedge clk); #1;
      check($sformatf("rd m%0d a%0d", m, a), rd_data, exp_rd(m, s, st, a));
   endtask

   initial begin
      int rs;
      int rst_step;
      // Reset state
      #2;
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_last", out_last, 0);
      check("rst_data", out_data, 0);
      check("rst_rd", rd_data, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Legacy ROM contents on the read port
      rd_addr = 7'd0;   @(posedge clk); #1; check("rom_0",   rd_data, 32'h0001);
      rd_addr = 7'd1;   @(posedge clk); #1; check("rom_1",   rd_data, 32'h0203);
      rd_addr = 7'd127; @(posedge clk); #1; check("rom_127", rd_data, 32'hFEFF);

      // Ramp, always ready
      run_stream(0, 0, 0, 1'b0, -1, -1);
      @(posedge clk); #1;
      check("done_once", done, 0);
      check("idle_busy", busy, 0);

      // Stride with random ready, wraps past 256
      run_stream(2, 3, 5, 1'b1, -1, -1);
      @(posedge clk); #1;
      for (int n = 0; n < 4; n++) rd_probe(2, 3, 5, $urandom_range(0, WORDS - 1));

      // Random stride configuration
      rs = $urandom_range(0, MASK);
      rst_step = $urandom_range(0, MASK);
      run_stream(2, rs, rst_step, 1'b1, -1, -1);
      @(posedge clk); #1;

      // start while busy is ignored; start in the done cycle launches a new stream
      run_stream(0, 8'h10, 0, 1'b1, 10, -1);
      run_stream(1, 8'h42, 0, 1'b0, -1, -1);
      @(posedge clk); #1;

      // Reset mid-stream
      run_stream(2, 7, 9, 1'b0, -1, 40);
      @(posedge clk); #1;
      check("abort_hold_done", done, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_abort_done", done, 0);
      check("post_abort_busy", busy, 0);
      run_stream(0, 0, 0, 1'b1, -1, -1);
      @(posedge clk); #1;

      // Mode 3: LFSR when enabled, otherwise identical to ramp
      run_stream(3, 8'h5A, 0, 1'b1, -1, -1);
      run_stream(3, 8'h5A, 0, 1'b0, -1, -1);
      @(posedge clk); #1;
      rd_probe(3, 8'h5A, 0, 5);
      rd_probe(3, 8'h5A, 0, 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end
endmodule
